serial_rx: RTL
==============

// Module: serial_rx
// PURPOSE
// - Receive side of the cnt-timed serial link: deserializes a word sent MSB first by the matching transmitter.
// - Shares the free-running cnt timebase with the transmitter: idle for n0 cnt ticks, then nbits bits of n1 ticks each.
// - Samples each bit at mid-bit, assembles the word right-justified and hands it to the consumer with valid/ack.
// PARAMETERS
// - P_W      256  data register width; nbits is clamped to P_W
// - P_Y_INIT 0    idle line level assumed at reset; also the reset value of the optional synchronizer flops
// PORTS
// - clk       in   1    clock
// - rst_n     in   1    synchronous active-low reset
// - en        in   1    1 = armed; 0 = FSM held in S_IDLE, partial frame discarded
// - x         in   1    serial line in
// - y0        in   1    expected idle level
// - nbits     in   8    bits per frame; 0 is treated as 1
// - n0        in   32   cnt ticks before the first bit; 0 is treated as 1
// - n1        in   32   cnt ticks per bit; 0 is treated as 1
// - cnt       in   32   shared timebase, same value the transmitter sees
// - data      out  P_W  received word; first bit received is at data[nbits-1]; bits above are 0
// - data_vld  out  1    word available; held until accepted
// - data_ack  in   1    consumer accepts the word on a cycle where data_vld=1 and data_ack=1
// - frm_err   out  1    qualifies data: line was not at y0 at the idle check
// - ovf       out  1    sticky: a frame completed while data_vld was still 1; cleared only by reset
// BEHAVIOUR
// - Reset (rst_n=0 at posedge clk): data=0, data_vld=0, frm_err=0, ovf=0; FSM=S_IDLE; shift register and bit count cleared.
// - Effective values: i_n0=max(n0,1), i_n1=max(n1,1), i_nb=min(max(nbits,1),P_W), half=i_n1>>1.
// - S_IDLE -> S_WAIT when en=1. All timing inputs are latched on entry to S_WAIT.
//   - Targets: t_chk=i_n0-1, t_smp=i_n0+half.
// - S_WAIT:
//   - cnt==t_chk: record err = (x != y0).
//   - cnt==t_smp: shift in x (sr <= {sr,x}), bit_cnt <= 1, t_smp += i_n1, go to S_BITS.
// - S_BITS: on cnt==t_smp, shift in x, bit_cnt++, t_smp += i_n1.
//   - On the i_nb-th sample (same cycle): data <= assembled word, zero-extended; frm_err <= err; data_vld <= 1.
//   - Then return to S_WAIT with targets recomputed, ready for the next cnt cycle.
// - Compare only with ==. A target that cnt never reaches leaves the FSM waiting; no timeout.
// - Target arithmetic is 32-bit and wraps modulo 2^32.
// - Latency: data_vld rises 1 clk after the clk on which cnt equals the last sample point.
// - Handshake:
//   - data_vld & data_ack -> data_vld=0 next clk. data and frm_err hold their values until the next frame completes.
//   - A completion on the same cycle as an ack: the new word wins, data_vld stays 1, ovf is not set.
//   - A completion while data_vld=1 and data_ack=0: data is overwritten, data_vld stays 1, ovf is set.
// - en falling mid-frame: next clk FSM=S_IDLE, sr and bit_cnt cleared; data, data_vld and ovf untouched.
// - Reset mid-frame: full reset as above. No partial word is ever presented.
// CONFIGURATION
// - SERIAL_RX_SYNC_EN defined:
//   - x passes through a 2-flop synchronizer (reset value P_Y_INIT) before the idle check and the sampler.
//   - Sampling still happens on the cnt match, so the sampled line state is 2 clk older than x.
// - SERIAL_RX_SYNC_EN undefined: x is used directly, for the case where x is already synchronous to clk.
// STRUCTURE
// - Shared package serial_pkg:
//   - FSM state encoding S_IDLE/S_WAIT/S_BITS.
//   - Width constants CNT_W=32, NB_W=8.
//   - Helper function clamp1() (0 -> 1).
// - One sub-module, serial_sync: parameterized 2-flop synchronizer. It is instantiated only under SERIAL_RX_SYNC_EN.
// TESTING (loop a serial_tx instance onto x, both on the same cnt)
// - nbits=8, n0=4, n1=4, tx data=0xA5 -> data=0x0A5, data_vld=1 once, frm_err=0.
// - nbits=1, n0=0, n1=0 (clamped to 1), tx bit=1 -> data=0x1; the sample lands on cnt==1.
// - Two back-to-back frames 0x3C then 0xC3, data_ack held 0 -> data=0xC3, ovf=1; then ack -> data_vld=0, ovf stays 1.
// - y0=1, force x=0 at cnt==n0-1, nbits=4, data=0x9 -> data=0x9, frm_err=1.
// - en drops after bit 3 of a 16-bit frame -> no data_vld; the next full frame 0xBEEF is received correctly.
// - rst_n=0 mid-frame with data_vld=1 -> next clk: data=0, data_vld=0, ovf=0, FSM=S_IDLE.
// - Run the whole suite with and without SERIAL_RX_SYNC_EN; the results must be identical for n1>=6.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the cnt-timed serial link: FSM encoding,
// width constants and the zero-to-one clamp used on timing inputs.
package serial_pkg;

    localparam int CNT_W = 32;
    localparam int NB_W  = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_BITS = 2'd2
    } state_t;

    // A zero count would never let the timebase advance a frame, so treat it as one.
    function automatic logic [CNT_W-1:0] clamp1(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

endpackage

// File: rtl/serial_sync.sv
// Parameterized 2-flop synchronizer for bringing the serial line into the clk domain.
module serial_sync
    import serial_pkg::*;
#(
    parameter int             P_W    = 1,
    parameter logic [P_W-1:0] P_INIT = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [P_W-1:0] d_i,
    output logic [P_W-1:0] q_o
);

    logic [P_W-1:0] s1_q;
    logic [P_W-1:0] s2_q;

    // Two back-to-back flops; both reset to the assumed idle level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= P_INIT;
            s2_q <= P_INIT;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/serial_rx.sv
// Receive side of the cnt-timed serial link. Waits n0 ticks of idle, then
// samples nbits bits of n1 ticks each at mid-bit, MSB first, and presents the
// right-justified word with a valid/ack handshake.
// Optional build macro SERIAL_RX_SYNC_EN: route x through a 2-flop synchronizer
// before the idle check and the sampler (sampled state is then 2 clk older).
module serial_rx
    import serial_pkg::*;
#(
    parameter int   P_W      = 256,
    parameter logic P_Y_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             x,
    input  logic             y0,
    input  logic [NB_W-1:0]  nbits,
    input  logic [CNT_W-1:0] n0,
    input  logic [CNT_W-1:0] n1,
    input  logic [CNT_W-1:0] cnt,
    output logic [P_W-1:0]   data,
    output logic             data_vld,
    input  logic             data_ack,
    output logic             frm_err,
    output logic             ovf
);

    logic x_s;

`ifdef SERIAL_RX_SYNC_EN
    serial_sync #(
        .P_W    (1),
        .P_INIT (P_Y_INIT)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (x),
        .q_o   (x_s)
    );
`else
    assign x_s = x;
`endif

    state_t           state_q, state_d;
    logic [P_W-1:0]   sr_q, sr_d;
    logic [NB_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic             err_q, err_d;
    logic [P_W-1:0]   data_q, data_d;
    logic             vld_q, vld_d;
    logic             frm_err_q, frm_err_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] t_chk_q, t_chk_d;
    logic [CNT_W-1:0] t_smp_q, t_smp_d;
    logic [CNT_W-1:0] n1_q, n1_d;
    logic [NB_W-1:0]  nb_q, nb_d;

    // Effective timing values derived from the live inputs; latched on entry to S_WAIT.
    logic [CNT_W-1:0] i_n0, i_n1, nb_c;
    logic [NB_W-1:0]  i_nb;
    logic [P_W-1:0]   sr_shift;
    logic [NB_W-1:0]  cnt_nx;

    assign i_n0     = clamp1(n0);
    assign i_n1     = clamp1(n1);
    assign nb_c     = clamp1(CNT_W'(nbits));
    assign i_nb     = (nb_c > CNT_W'(P_W)) ? NB_W'(P_W) : NB_W'(nb_c);
    assign sr_shift = (sr_q << 1) | P_W'(x_s);
    assign cnt_nx   = (state_q == S_WAIT) ? NB_W'(1) : bit_cnt_q + NB_W'(1);

    // Next-state, sampling, word completion and valid/ack/overflow bookkeeping.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        err_d     = err_q;
        data_d    = data_q;
        vld_d     = vld_q;
        frm_err_d = frm_err_q;
        ovf_d     = ovf_q;
        t_chk_d   = t_chk_q;
        t_smp_d   = t_smp_q;
        n1_d      = n1_q;
        nb_d      = nb_q;

        // An ack retires the word unless a completion below re-asserts valid.
        if (vld_q && data_ack) begin
            vld_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d   = S_WAIT;
                    sr_d      = '0;
                    bit_cnt_d = '0;
                    t_chk_d   = i_n0 - CNT_W'(1);
                    t_smp_d   = i_n0 + (i_n1 >> 1);
                    n1_d      = i_n1;
                    nb_d      = i_nb;
                end
            end
            S_WAIT, S_BITS: begin
                if (!en) begin
                    state_d   = S_IDLE;
                    sr_d      = '0;
                    bit_cnt_d = '0;
                end else begin
                    if (state_q == S_WAIT && cnt == t_chk_q) begin
                        err_d = (x_s != y0);
                    end
                    if (cnt == t_smp_q) begin
                        if (cnt_nx == nb_q) begin
                            // Last bit: publish the word and rearm for the next cnt cycle.
                            data_d    = sr_shift;
                            frm_err_d = err_q;
                            vld_d     = 1'b1;
                            if (vld_q && !data_ack) begin
                                ovf_d = 1'b1;
                            end
                            state_d   = S_WAIT;
                            sr_d      = '0;
                            bit_cnt_d = '0;
                            t_chk_d   = i_n0 - CNT_W'(1);
                            t_smp_d   = i_n0 + (i_n1 >> 1);
                            n1_d      = i_n1;
                            nb_d      = i_nb;
                        end else begin
                            state_d   = S_BITS;
                            sr_d      = sr_shift;
                            bit_cnt_d = cnt_nx;
                            t_smp_d   = t_smp_q + n1_q;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control, shift register and output registers; all cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            err_q     <= 1'b0;
            data_q    <= '0;
            vld_q     <= 1'b0;
            frm_err_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            err_q     <= err_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
            frm_err_q <= frm_err_d;
            ovf_q     <= ovf_d;
        end
    end

    // Latched frame timing; only meaningful once S_WAIT has been entered.
    always_ff @(posedge clk) begin
        t_chk_q <= t_chk_d;
        t_smp_q <= t_smp_d;
        n1_q    <= n1_d;
        nb_q    <= nb_d;
    end

    assign data     = data_q;
    assign data_vld = vld_q;
    assign frm_err  = frm_err_q;
    assign ovf      = ovf_q;

endmodule
